// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program-counter generator at the head of the fetch stage.
//
// Drives the instruction-memory address (pc) and chip enable (ce). The pc
// advances by INST_BYTES only when instruction memory accepts a fetch. It
// also supports a pipeline stall, a branch redirect and a flush redirect.
// A branch that arrives while the pipeline is stalled is buffered and
// applied on the first unstalled cycle. A flush overrides everything,
// including a buffered branch.
//
// Parameters:
//   ADDR_W      width of pc and of both redirect target buses
//   INST_BYTES  bytes per instruction (1, 2, 4 or 8); also the pc step
//   RESET_VEC   first fetch address after reset release
//
// Ports:
//   clk            in   clock; all state changes on its rising edge
//   rst            in   synchronous reset, active low
//   stall          in   pipeline stall; pc is held
//   fetch_ack      in   instruction memory accepted the fetch at pc
//   branch_flag    in   branch/jump redirect request
//   branch_target  in   redirect address for branch_flag
//   flush          in   exception/flush redirect; highest priority
//   new_pc         in   redirect address for flush
//   pc             out  registered fetch address
//   ce             out  registered instruction-memory enable
//   pc_misalign    out  one-cycle pulse, aligned with the new pc, when the
//                       redirect that produced it had nonzero low bits
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int                 ADDR_W     = 32,
    parameter int                 INST_BYTES = 4,
    parameter logic [ADDR_W-1:0]  RESET_VEC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              fetch_ack,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pc_misalign
);

    // Low address bits that must be zero for an instruction-aligned pc.
    // For INST_BYTES=1 this is all zeros, so no masking happens and the
    // misalign pulse can never fire.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INST_BYTES);

    // OFF : held in / just out of reset, ce low
    // RUN : fetching, nothing buffered
    // HOLD: fetching (or stalled) with a branch buffered in pend_target_q
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q,       state_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic              ce_q,          ce_d;
    logic              misalign_q,    misalign_d;
    logic              pend_valid_q,  pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    // Redirect selection is shared by flush, live branch and buffered
    // branch so the alignment/misalign logic exists only once.
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ce_d            = ce_q;
        misalign_d      = 1'b0;
        pend_valid_d    = pend_valid_q;
        pend_target_d   = pend_target_q;
        redirect        = 1'b0;
        redirect_target = '0;

        unique case (state_q)
            ST_OFF: begin
                // First cycle out of reset: enable fetch at the reset vector
                // and ignore every other input.
                state_d = ST_RUN;
                ce_d    = 1'b1;
                pc_d    = RESET_VEC;
            end

            ST_RUN, ST_HOLD: begin
                ce_d = 1'b1;
                if (flush) begin
                    redirect        = 1'b1;
                    redirect_target = new_pc;
                    pend_valid_d    = 1'b0;
                    state_d         = ST_RUN;
                end else if (stall && branch_flag) begin
                    // Later branches in the same stall overwrite the buffer.
                    pend_target_d = branch_target;
                    pend_valid_d  = 1'b1;
                    state_d       = ST_HOLD;
                end else if (stall) begin
                    // Hold everything, including any buffered branch.
                end else if (branch_flag) begin
                    // A live branch supersedes a buffered one.
                    redirect        = 1'b1;
                    redirect_target = branch_target;
                    pend_valid_d    = 1'b0;
                    state_d         = ST_RUN;
                end else if (pend_valid_q) begin
                    // Stall just released: apply the buffered branch. The
                    // fetch at the old pc is abandoned, so fetch_ack is moot.
                    redirect        = 1'b1;
                    redirect_target = pend_target_q;
                    pend_valid_d    = 1'b0;
                    state_d         = ST_RUN;
                end else if (fetch_ack) begin
                    pc_d = pc_q + PC_STEP;   // wraps modulo 2^ADDR_W
                end
            end

            default: begin
                state_d = ST_OFF;
                ce_d    = 1'b0;
            end
        endcase

        if (redirect) begin
            pc_d       = redirect_target & ~LOW_MASK;
            misalign_d = |(redirect_target & LOW_MASK);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_OFF;
            pc_q          <= RESET_VEC;
            ce_q          <= 1'b0;
            misalign_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ce_q          <= ce_d;
            misalign_q    <= misalign_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc          = pc_q;
    assign ce          = ce_q;
    assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen.
//
// Two instances: dut (defaults: 32-bit, 4-byte instructions, reset vector 0)
// and dut16 (16-bit, 2-byte instructions, reset vector 0x0100). Every
// driven cycle pushes the expected registered outputs to a queue; after the
// clock edge the entry is popped and compared against the DUT.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- default instance --------------------------------------------------
    logic        rst = 1'b0, stall = 1'b0, fetch_ack = 1'b0;
    logic        branch_flag = 1'b0, flush = 1'b0;
    logic [31:0] branch_target = '0, new_pc = '0;
    logic [31:0] pc;
    logic        ce, pc_misalign;

    pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .fetch_ack     (fetch_ack),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .new_pc        (new_pc),
        .pc            (pc),
        .ce            (ce),
        .pc_misalign   (pc_misalign)
    );

    // ---- 16-bit / 2-byte instance ------------------------------------------
    logic        rst16 = 1'b0, ack16 = 1'b0, br16 = 1'b0;
    logic [15:0] bt16 = '0;
    logic [15:0] pc16;
    logic        ce16, mis16;

    pc_gen #(.ADDR_W(16), .INST_BYTES(2), .RESET_VEC(16'h0100)) dut16 (
        .clk           (clk),
        .rst           (rst16),
        .stall         (1'b0),
        .fetch_ack     (ack16),
        .branch_flag   (br16),
        .branch_target (bt16),
        .flush         (1'b0),
        .new_pc        (16'h0000),
        .pc            (pc16),
        .ce            (ce16),
        .pc_misalign   (mis16)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        ce;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb16_q[$];

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model state for the default instance.
    logic        m_run = 1'b0;
    logic [31:0] m_pc  = '0;
    logic        m_pv  = 1'b0;
    logic [31:0] m_pt  = '0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the default instance, with model update.
    task automatic drive(input logic r, input logic s, input logic a,
                         input logic b, input logic [31:0] bt,
                         input logic f, input logic [31:0] np);
        exp_t        e;
        exp_t        got;
        logic        redir;
        logic [31:0] tgt;
        @(negedge clk);
        rst = r; stall = s; fetch_ack = a;
        branch_flag = b; branch_target = bt; flush = f; new_pc = np;

        redir = 1'b0;
        tgt   = '0;
        e.mis = 1'b0;
        if (!r) begin
            m_run = 1'b0; m_pc = 32'h0; m_pv = 1'b0; m_pt = 32'h0;
        end else if (!m_run) begin
            m_run = 1'b1; m_pc = 32'h0;
        end else if (f) begin
            redir = 1'b1; tgt = np; m_pv = 1'b0;
        end else if (s && b) begin
            m_pt = bt; m_pv = 1'b1;
        end else if (s) begin
            m_pv = m_pv;
        end else if (b) begin
            redir = 1'b1; tgt = bt; m_pv = 1'b0;
        end else if (m_pv) begin
            redir = 1'b1; tgt = m_pt; m_pv = 1'b0;
        end else if (a) begin
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            m_pc  = {tgt[31:2], 2'b00};
            e.mis = |tgt[1:0];
        end
        e.pc = m_pc;
        e.ce = m_run;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        txn++;
        $display("txn %0d: rst=%b stall=%b ack=%b br=%b flush=%b -> pc=%h ce=%b mis=%b",
                 txn, r, s, a, b, f, pc, ce, pc_misalign);
        check_val("pc", pc, got.pc);
        check_val("ce", {31'b0, ce}, {31'b0, got.ce});
        check_val("pc_misalign", {31'b0, pc_misalign}, {31'b0, got.mis});
    endtask

    // One clock on the 16-bit instance; expectations given as constants.
    task automatic drive16(input logic r, input logic a, input logic b,
                           input logic [15:0] bt, input logic [15:0] epc,
                           input logic ece, input logic emis);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst16 = r; ack16 = a; br16 = b; bt16 = bt;
        e.pc  = {16'h0, epc};
        e.ce  = ece;
        e.mis = emis;
        sb16_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb16_q.pop_front();
        txn++;
        $display("txn %0d: [w16] rst=%b ack=%b br=%b -> pc=%h ce=%b mis=%b",
                 txn, r, a, b, pc16, ce16, mis16);
        check_val("pc16", {16'h0, pc16}, got.pc);
        check_val("ce16", {31'b0, ce16}, {31'b0, got.ce});
        check_val("pc_misalign16", {31'b0, mis16}, {31'b0, got.mis});
    endtask

    initial begin
        // Reset release with continuous ack: 0, 4, 8, C, 10.
        repeat (3) drive(0, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        check_val("first_fetch", pc, 32'h0);
        repeat (4) drive(1, 0, 1, 0, 0, 0, 0);
        check_val("seq_0x10", pc, 32'h10);

        // Stall/ack gating.
        repeat (2) drive(1, 1, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check_val("gated_hold", pc, 32'h10);
        drive(1, 0, 1, 0, 0, 0, 0);
        check_val("gated_step", pc, 32'h14);

        // Buffered branch applied on stall release, ack ignored that cycle.
        drive(1, 1, 1, 1, 32'h200, 0, 0);
        repeat (3) drive(1, 1, 1, 0, 0, 0, 0);
        check_val("frozen", pc, 32'h14);
        drive(1, 0, 1, 0, 0, 0, 0);
        check_val("buffered_branch", pc, 32'h200);
        drive(1, 0, 1, 0, 0, 0, 0);
        check_val("after_buffered", pc, 32'h204);

        // Flush beats a live branch and discards the buffered one.
        drive(1, 1, 0, 1, 32'h200, 0, 0);
        drive(1, 1, 0, 1, 32'h300, 1, 32'h80);
        check_val("flush_prio", pc, 32'h80);
        drive(1, 0, 0, 0, 0, 0, 0);
        check_val("no_stale_pend", pc, 32'h80);

        // Misaligned redirects and wrap-around.
        drive(1, 0, 1, 1, 32'h1006, 0, 0);
        check_val("misalign_pc", pc, 32'h1004);
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h83);
        drive(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        check_val("wrap", pc, 32'h0);
        drive(1, 1, 0, 1, 32'h2003, 0, 0);
        drive(1, 1, 0, 1, 32'h3001, 0, 0);   // overwrites buffered target
        drive(1, 0, 0, 0, 0, 0, 0);
        check_val("pend_overwrite", pc, 32'h3000);

        // Reset during HOLD discards the buffered branch.
        drive(1, 1, 0, 1, 32'h500, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        check_val("reset_discards", pc, 32'h4);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 40) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 5) == 0), $urandom(),
                  ($urandom_range(0, 12) == 0), $urandom());
        end

        // 16-bit / 2-byte instance.
        drive16(0, 1, 0, 16'h0,    16'h0100, 0, 0);
        drive16(0, 1, 0, 16'h0,    16'h0100, 0, 0);
        drive16(1, 1, 0, 16'h0,    16'h0100, 1, 0);
        drive16(1, 1, 0, 16'h0,    16'h0102, 1, 0);
        drive16(1, 1, 1, 16'hFFFE, 16'hFFFE, 1, 0);
        drive16(1, 1, 0, 16'h0,    16'h0000, 1, 0);
        drive16(1, 0, 1, 16'h0123, 16'h0122, 1, 1);
        drive16(1, 0, 0, 16'h0,    16'h0122, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator at the head of the fetch stage. It drives the instruction-memory address and chip enable. It advances only when instruction memory accepts a fetch, and it supports pipeline stall, branch redirect and flush redirect. A branch that arrives during a stall is buffered and applied when the stall releases; flush overrides everything.

Parameters:
ADDR_W, 32, width of pc and of all target buses
INST_BYTES, 4, bytes per instruction; must be a power of two (1, 2, 4 or 8); pc increment step
RESET_VEC, 0, address of the first fetch after reset release (ADDR_W bits)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-low (rst==0 at a posedge resets)
stall  input  1  pipeline stall; hold pc
fetch_ack  input  1  instruction memory accepted the fetch at the current pc this cycle
branch_flag  input  1  branch/jump redirect request
branch_target  input  ADDR_W  redirect address for branch_flag
flush  input  1  exception/flush redirect; highest priority
new_pc  input  ADDR_W  redirect address for flush
pc  output  ADDR_W  fetch address (registered)
ce  output  1  instruction-memory enable (registered)
pc_misalign  output  1  one-cycle pulse: the last redirect target had nonzero low bits

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-low. All state is updated only at posedge clk.
- Reset (rst==0 at a posedge):
  - state<=OFF, ce<=0, pc<=RESET_VEC, pc_misalign<=0.
  - pend_valid<=0, pend_target<=0.
  - Reset applied mid-operation discards any pending branch.
- States:
  - OFF: ce=0. The first posedge with rst==1 moves to RUN with ce<=1 and pc held at RESET_VEC. The first fetch address is therefore RESET_VEC, one cycle after reset release. All other inputs are ignored in OFF.
  - RUN: no pending branch.
  - HOLD: pend_valid=1 (branch captured under stall).
- Per-posedge update in RUN/HOLD, first matching rule wins:
  1. flush=1: pc<=new_pc (aligned), pend_valid<=0, state<=RUN. Applies regardless of stall.
  2. stall=1 and branch_flag=1: pend_target<=branch_target, pend_valid<=1, state<=HOLD, pc held. A later branch during the same stall overwrites pend_target.
  3. stall=1: pc held; pend_valid and state held.
  4. branch_flag=1: pc<=branch_target (aligned), pend_valid<=0, state<=RUN. A live branch beats a buffered one.
  5. pend_valid=1: pc<=pend_target (aligned), pend_valid<=0, state<=RUN. fetch_ack is ignored this cycle.
  6. fetch_ack=1: pc<=pc+INST_BYTES, modulo 2^ADDR_W; 0xFFFFFFFC+4 gives 0x00000000 for the defaults.
  7. Otherwise: pc held.
- ce stays 1 in RUN and HOLD, including while stalled.
- Alignment:
  - "Aligned" means the low log2(INST_BYTES) bits are forced to 0.
  - pc_misalign<=1 for exactly one cycle, coincident with the new pc, when a redirect (rules 1, 4, 5) carried nonzero low bits. Otherwise pc_misalign<=0.
  - For INST_BYTES=1 there is no masking and pc_misalign stays 0.
- Latency: every redirect and increment is visible on pc the cycle after the causing posedge. Latency from stall release to buffered target on pc is 1 cycle.
- Redirect targets must be held stable by the producer while their flag is high; they are sampled only at the posedge.

Test Plan:
- Reset release: rst=0 for 3 cycles, then 1, fetch_ack=1 continuous -> ce=0 and pc=0 during reset; cycle 1 after release ce=1, pc=0x0; then 0x4, 0x8, 0xC.
- Stall/ack gating: pc=0x10, stall=1 for 2 cycles, then stall=0 with fetch_ack=0 for 1 cycle -> pc stays 0x10 for 3 cycles, then 0x14 after fetch_ack=1.
- Buffered branch: stall=1, branch_flag=1, target=0x200 for one cycle, stall held 3 more cycles -> pc frozen; on the cycle after stall drops pc=0x200 with fetch_ack=1 ignored; the next ack gives 0x204.
- Flush priority: stall=1, pending target 0x200, then flush=1 with new_pc=0x80 and branch_flag=1 with target 0x300 in the same cycle -> pc=0x80, pend_valid=0; stall release does not go to 0x200.
- Misalign and wrap: branch target 0x1006 -> pc=0x1004 and pc_misalign high for 1 cycle. pc=0xFFFFFFFC with fetch_ack -> pc=0x00000000.
- Reset mid-operation and parameters: rst=0 during HOLD -> next cycle pc=RESET_VEC, ce=0, pending discarded. Rerun with ADDR_W=16, INST_BYTES=2, RESET_VEC=0x0100 -> sequence 0x0100, 0x0102; pc=0xFFFE with ack -> 0x0000.
